// File: rtl/exec_alu_unit_pkg.sv
// ============================================================================
// exec_alu_unit_pkg : shared codes for the LEGv8 execute stage
// Rev 1.0
// ============================================================================
`default_nettype none

package exec_alu_unit_pkg;

  localparam int WIDTH_DEF = 64;

  typedef enum logic [1:0] {
    ALUOP_LDST  = 2'b00,
    ALUOP_CBZ   = 2'b01,
    ALUOP_RTYPE = 2'b10,
    ALUOP_RSVD  = 2'b11
  } aluop_e;

  typedef enum logic [3:0] {
    ALU_AND   = 4'b0000,
    ALU_ORR   = 4'b0001,
    ALU_ADD   = 4'b0010,
    ALU_SUB   = 4'b0110,
    ALU_PASSB = 4'b0111,
    ALU_NOR   = 4'b1100
  } aluctl_e;

  localparam logic [10:0] OPC_ADD = 11'b10001011000;
  localparam logic [10:0] OPC_SUB = 11'b11001011000;
  localparam logic [10:0] OPC_AND = 11'b10001010000;
  localparam logic [10:0] OPC_ORR = 11'b10101010000;

endpackage

`default_nettype wire

// File: rtl/exec_alu_core.sv
// ============================================================================
// exec_alu_core : combinational 64-bit ALU with zero detection
// Rev 1.0
// ============================================================================
`default_nettype none

module exec_alu_core
  import exec_alu_unit_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [3:0]       ctl_i,
  output logic [WIDTH-1:0] result_o,
  output logic             zero_o
);

  always_comb begin
    result_o = '0;
    case (ctl_i)
      ALU_AND:   result_o = a_i & b_i;
      ALU_ORR:   result_o = a_i | b_i;
      ALU_ADD:   result_o = a_i + b_i;
      ALU_SUB:   result_o = a_i - b_i;
      ALU_PASSB: result_o = b_i;
      ALU_NOR:   result_o = ~(a_i | b_i);
      default:   result_o = '0;
    endcase
  end

  assign zero_o = (result_o == '0);

endmodule

`default_nettype wire

// File: rtl/exec_alu_unit.sv
// ============================================================================
// exec_alu_unit : registered execute stage (decode, ALU, PC+4, branch target)
// Rev 1.0
// ============================================================================
`default_nettype none

module exec_alu_unit
  import exec_alu_unit_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [1:0]       alu_op,
  input  logic [10:0]      opcode,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic [WIDTH-1:0] pc,
  input  logic [WIDTH-1:0] imm,
  output logic             out_valid,
  output logic [3:0]       alu_ctl,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic [WIDTH-1:0] pc_plus4,
  output logic [WIDTH-1:0] branch_target,
  output logic             illegal
);

  logic [3:0]       alu_ctl_d,  alu_ctl_q;
  logic             illegal_d,  illegal_q;
  logic [WIDTH-1:0] result_d,   result_q;
  logic             zero_d,     zero_q;
  logic [WIDTH-1:0] pc_plus4_d, pc_plus4_q;
  logic [WIDTH-1:0] br_tgt_d,   br_tgt_q;
  logic             valid_q;

  // Reserved ALUOp falls back to ADD without flagging; only R-type can be illegal.
  always_comb begin
    alu_ctl_d = ALU_ADD;
    illegal_d = 1'b0;
    case (alu_op)
      ALUOP_LDST: alu_ctl_d = ALU_ADD;
      ALUOP_CBZ:  alu_ctl_d = ALU_PASSB;
      ALUOP_RTYPE: begin
        case (opcode)
          OPC_ADD: alu_ctl_d = ALU_ADD;
          OPC_SUB: alu_ctl_d = ALU_SUB;
          OPC_AND: alu_ctl_d = ALU_AND;
          OPC_ORR: alu_ctl_d = ALU_ORR;
          default: begin
            alu_ctl_d = ALU_ADD;
            illegal_d = 1'b1;
          end
        endcase
      end
      default: alu_ctl_d = ALU_ADD;
    endcase
  end

  exec_alu_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .a_i      (op_a),
    .b_i      (op_b),
    .ctl_i    (alu_ctl_d),
    .result_o (result_d),
    .zero_o   (zero_d)
  );

  assign pc_plus4_d = pc + WIDTH'(4);
  assign br_tgt_d   = pc + (imm << 2);

  always_ff @(posedge clk) begin
    if (!reset) begin
      valid_q    <= 1'b0;
      alu_ctl_q  <= '0;
      illegal_q  <= 1'b0;
      result_q   <= '0;
      zero_q     <= 1'b0;
      pc_plus4_q <= '0;
      br_tgt_q   <= '0;
    end else begin
      valid_q <= in_valid;
      if (in_valid) begin
        alu_ctl_q  <= alu_ctl_d;
        illegal_q  <= illegal_d;
        result_q   <= result_d;
        zero_q     <= zero_d;
        pc_plus4_q <= pc_plus4_d;
        br_tgt_q   <= br_tgt_d;
      end
    end
  end

  assign out_valid     = valid_q;
  assign alu_ctl       = alu_ctl_q;
  assign illegal       = illegal_q;
  assign result        = result_q;
  assign zero          = zero_q;
  assign pc_plus4      = pc_plus4_q;
  assign branch_target = br_tgt_q;

endmodule

`default_nettype wire

// File: tb/tb_exec_alu_unit.sv
// ============================================================================
// tb_exec_alu_unit : directed and random checks against a behavioural model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_exec_alu_unit;

  localparam int W = 64;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic [1:0]   alu_op;
  logic [10:0]  opcode;
  logic [W-1:0] op_a, op_b, pc, imm;
  logic         out_valid, zero, illegal;
  logic [3:0]   alu_ctl;
  logic [W-1:0] result, pc_plus4, branch_target;

  always #5 clk = ~clk;

  exec_alu_unit #(.WIDTH(W)) dut (
    .clk           (clk),
    .reset         (reset),
    .in_valid      (in_valid),
    .alu_op        (alu_op),
    .opcode        (opcode),
    .op_a          (op_a),
    .op_b          (op_b),
    .pc            (pc),
    .imm           (imm),
    .out_valid     (out_valid),
    .alu_ctl       (alu_ctl),
    .result        (result),
    .zero          (zero),
    .pc_plus4      (pc_plus4),
    .branch_target (branch_target),
    .illegal       (illegal)
  );

  int n_total = 0;
  int n_bad   = 0;

  logic         m_valid, m_zero, m_ill;
  logic [3:0]   m_ctl;
  logic [W-1:0] m_res, m_p4, m_bt;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: instruction table lookup, then the arithmetic it names.
  task automatic ref_exec(input logic [1:0] aop, input logic [10:0] opc,
                          input logic [W-1:0] a, input logic [W-1:0] b,
                          output logic [3:0] ctl, output logic ill, output logic [W-1:0] res);
    ill = 1'b0;
    if (aop == 2'b01)       ctl = 4'b0111;
    else if (aop != 2'b10)  ctl = 4'b0010;
    else if (opc == 11'b10001011000) ctl = 4'b0010;
    else if (opc == 11'b11001011000) ctl = 4'b0110;
    else if (opc == 11'b10001010000) ctl = 4'b0000;
    else if (opc == 11'b10101010000) ctl = 4'b0001;
    else begin ctl = 4'b0010; ill = 1'b1; end
    if      (ctl == 4'b0111) res = b;
    else if (ctl == 4'b0110) res = a - b;
    else if (ctl == 4'b0000) res = a & b;
    else if (ctl == 4'b0001) res = a | b;
    else                     res = a + b;
  endtask

  task automatic check_all(input string ph);
    chk({ph, ".valid"},   W'(out_valid), W'(m_valid));
    chk({ph, ".ctl"},     W'(alu_ctl),   W'(m_ctl));
    chk({ph, ".illegal"}, W'(illegal),   W'(m_ill));
    chk({ph, ".result"},  result,        m_res);
    chk({ph, ".zero"},    W'(zero),      W'(m_zero));
    chk({ph, ".pc4"},     pc_plus4,      m_p4);
    chk({ph, ".btgt"},    branch_target, m_bt);
  endtask

  task automatic step(input string ph, input logic rst_n, input logic v,
                      input logic [1:0] aop, input logic [10:0] opc,
                      input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [W-1:0] p, input logic [W-1:0] i);
    reset = rst_n; in_valid = v; alu_op = aop; opcode = opc;
    op_a = a; op_b = b; pc = p; imm = i;
    @(posedge clk);
    if (!rst_n) begin
      m_valid = 0; m_ctl = 0; m_ill = 0; m_res = 0; m_zero = 0; m_p4 = 0; m_bt = 0;
    end else begin
      m_valid = v;
      if (v) begin
        ref_exec(aop, opc, a, b, m_ctl, m_ill, m_res);
        m_zero = (m_res == 0);
        m_p4   = p + 4;
        m_bt   = p + i * 4;
      end
    end
    #1;
    check_all(ph);
  endtask

  localparam logic [10:0] ADD = 11'b10001011000;
  localparam logic [10:0] SUB = 11'b11001011000;
  localparam logic [10:0] AND = 11'b10001010000;
  localparam logic [10:0] ORR = 11'b10101010000;

  initial begin
    logic [10:0] opcs [4];
    opcs[0] = ADD; opcs[1] = SUB; opcs[2] = AND; opcs[3] = ORR;

    reset = 0; in_valid = 0; alu_op = 0; opcode = 0;
    op_a = 0; op_b = 0; pc = 0; imm = 0;

    step("rst0", 0, 1, 2'b10, ADD, 64'h55, 64'h77, 64'h100, 64'h9);
    step("rst1", 0, 1, 2'b10, SUB, 64'h12, 64'h34, 64'h200, 64'h5);
    chk("rst.result", result, 64'h0);
    chk("rst.valid", W'(out_valid), 64'h0);

    step("add", 1, 1, 2'b10, ADD, 64'h0F, 64'h3C, 64'h40, 64'd3);
    chk("add.const", result, 64'h4B);
    chk("add.ctl", W'(alu_ctl), 64'h2);
    chk("add.pc4", pc_plus4, 64'h44);
    chk("add.btgt", branch_target, 64'h4C);
    step("sub", 1, 1, 2'b10, SUB, 64'h0F, 64'h3C, 64'h40, -64'sd2);
    chk("sub.const", result, 64'hFFFF_FFFF_FFFF_FFD3);
    chk("sub.btgt", branch_target, 64'h38);
    step("and", 1, 1, 2'b10, AND, 64'h0F, 64'h3C, 64'hFFFF_FFFF_FFFF_FFFC, 64'd0);
    chk("and.const", result, 64'h0C);
    chk("wrap.pc4", pc_plus4, 64'h0);
    step("orr", 1, 1, 2'b10, ORR, 64'h0F, 64'h3C, 64'h80, 64'd1);
    chk("orr.const", result, 64'h3F);
    chk("orr.illegal", W'(illegal), 64'h0);

    step("cbz0", 1, 1, 2'b01, 11'h0, 64'h99, 64'h0, 64'h10, 64'd0);
    chk("cbz0.zero", W'(zero), 64'h1);
    step("cbz5", 1, 1, 2'b01, 11'h0, 64'h99, 64'h5, 64'h10, 64'd0);
    chk("cbz5.result", result, 64'h5);
    step("ldst", 1, 1, 2'b00, 11'h7FF, 64'h1000, 64'h18, 64'h20, 64'd2);
    chk("ldst.result", result, 64'h1018);
    chk("ldst.illegal", W'(illegal), 64'h0);
    step("ill", 1, 1, 2'b10, 11'b11111111111, 64'h1, 64'h2, 64'h20, 64'd2);
    chk("ill.flag", W'(illegal), 64'h1);
    chk("ill.ctl", W'(alu_ctl), 64'h2);

    step("sub77", 1, 1, 2'b10, SUB, 64'd7, 64'd7, 64'h300, 64'd4);
    chk("sub77.zero", W'(zero), 64'h1);
    step("hold", 1, 0, 2'b10, ADD, 64'h123, 64'h456, 64'h999, 64'd8);
    chk("hold.valid", W'(out_valid), 64'h0);
    chk("hold.result", result, 64'h0);
    chk("hold.pc4", pc_plus4, 64'h304);

    step("pre", 1, 1, 2'b10, ORR, 64'hF0, 64'h0F, 64'h50, 64'd1);
    step("midrst", 0, 1, 2'b10, ORR, 64'hF0, 64'h0F, 64'h50, 64'd1);
    chk("midrst.result", result, 64'h0);

    for (int k = 0; k < 400; k++) begin
      logic [W-1:0] a, b;
      logic [10:0]  opc;
      a = {$urandom, $urandom};
      b = ($urandom_range(0, 7) == 0) ? a : {$urandom, $urandom};
      if ($urandom_range(0, 9) == 0) b = 0;
      opc = ($urandom_range(0, 4) == 0) ? 11'($urandom) : opcs[$urandom_range(0, 3)];
      step("rnd", ($urandom_range(0, 19) != 0), ($urandom_range(0, 3) != 0),
           2'($urandom), opc, a, b, {$urandom, $urandom}, {$urandom, $urandom});
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/exec_alu_unit.md
Name: exec_alu_unit

Overview:
- Registered execute-stage block for the single-cycle/pipelined LEGv8-style CPU.
- Decodes ALUOp plus the 11-bit opcode into a 4-bit ALU operation.
- Performs the 64-bit ALU operation and sets the zero flag.
- Computes PC+4 and the branch target (PC + offset<<2). All results are registered with one-cycle latency.

Parameters:
- WIDTH, 64, datapath width for operands, PC and results.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-low reset (0 = reset)
- in_valid  in  1  inputs below are valid this cycle
- alu_op  in  2  from Controller: 00 load/store, 01 CBZ, 10 R-type, 11 reserved
- opcode  in  11  instruction[31:21]
- op_a  in  WIDTH  register read data A
- op_b  in  WIDTH  ALU source mux output (register B or sign-extended immediate)
- pc  in  WIDTH  current instruction address
- imm  in  WIDTH  sign-extended branch offset, in words
- out_valid  out  1  registered in_valid
- alu_ctl  out  4  registered decoded ALU operation
- result  out  WIDTH  registered ALU result
- zero  out  1  registered (result == 0)
- pc_plus4  out  WIDTH  registered pc + 4
- branch_target  out  WIDTH  registered pc + (imm << 2)
- illegal  out  1  registered: R-type opcode not recognised

Behaviour:
- Reset: when reset==0 at a rising clk edge, all outputs are forced to 0 at that edge, including zero. This applies mid-operation; pending inputs are discarded.
- Register update: on each clk edge with reset==1, every output register loads its combinational value. out_valid is loaded from in_valid.
- Hold: when in_valid==0, all data outputs hold their previous values. Only out_valid updates, to 0.
- Latency: exactly 1 cycle. Throughput: one operation per cycle.
- Control decode (alu_ctl):
  - alu_op 00 -> 0010 (ADD, address calculation).
  - alu_op 01 -> 0111 (pass op_b, for CBZ).
  - alu_op 11 -> 0010 (ADD).
  - alu_op 10 decodes opcode:
    - 10001011000 -> 0010 ADD
    - 11001011000 -> 0110 SUB
    - 10001010000 -> 0000 AND
    - 10101010000 -> 0001 ORR
    - any other value -> 0010 ADD, with illegal=1.
  - illegal is 0 for every alu_op other than 10.
- ALU functions (alu_ctl):
  - 0000: a & b
  - 0001: a | b
  - 0010: a + b
  - 0110: a - b
  - 0111: b
  - 1100: ~(a | b)
  - any other code: result 0.
- ALU arithmetic is modulo 2^WIDTH. No carry or overflow outputs.
- zero is computed from the same-cycle result, before registering.
- Adders: pc_plus4 = pc + 4; branch_target = pc + {imm[WIDTH-3:0], 2'b00}. Both wrap modulo 2^WIDTH. imm's top 2 bits are discarded by the shift.
- Branch decision (Branch & zero) and next-PC muxing are done outside this block.

Decomposition:
- Shared package holds:
  - ALUOp codes (00/01/10/11).
  - 4-bit ALU control codes (AND, ORR, ADD, SUB, PASSB, NOR).
  - 11-bit R-type opcodes (ADD, SUB, AND, ORR).
  - WIDTH default.
- One natural sub-module: exec_alu_core, the combinational ALU plus zero detection.
- Decode and the two adders stay inline in exec_alu_unit.

Test Plan:
- Reset: drive reset=0 for 2 cycles with in_valid=1 and nonzero inputs -> all outputs 0, out_valid=0. Release reset -> first result appears 1 cycle later.
- R-type set, alu_op=10, op_a=0x0F, op_b=0x3C:
  - ADD -> result 0x4B, alu_ctl 0010
  - SUB -> result 0xFFFF_FFFF_FFFF_FFD3
  - AND -> 0x0C
  - ORR -> 0x3F
  - zero=0 and illegal=0 in every case.
- CBZ, alu_op=01:
  - op_b=0 -> result 0, zero=1.
  - op_b=5 -> result 5, zero=0.
- Load/store, alu_op=00, op_a=0x1000, op_b=0x18 -> result 0x1018. Illegal opcode 11111111111 with alu_op=10 -> alu_ctl 0010, illegal=1.
- Adders:
  - pc=0x40, imm=3 -> pc_plus4 0x44, branch_target 0x4C.
  - pc=0x40, imm=-2 -> branch_target 0x38.
  - pc=0xFFFF_FFFF_FFFF_FFFC -> pc_plus4 0 (wrap).
- Hold/valid: in_valid=1 for one cycle, then 0 with new inputs -> outputs keep the first values, out_valid falls to 0 one cycle later. SUB of equal operands (7-7) -> zero=1.
